imem_dmem_arbiter: RTL and testbench

- Shares one single-port unified memory between the instruction-fetch port (IF) and the load/store port (LSU) of the RV32I core.
- Uses a req/gnt/rvalid handshake and allows exactly one outstanding memory transaction.
- Arbitration is LSU-priority with an anti-starvation counter that guarantees fetch progress.
- Sits between the core's fetch/LSU stages and the memory model.

---
 rtl/imem_dmem_arbiter_pkg.sv | 35 +++
 rtl/imem_dmem_arbiter_pick.sv | 40 ++++
 rtl/imem_dmem_arbiter.sv | 146 ++++++++++++++
 tb/tb_imem_dmem_arbiter.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
//   arb_state_e : arbiter FSM states
//   arb_owner_e : which requester owns the in-flight memory transaction
//   mem_req_t   : registered memory request fields
//   BE_WORD     : full-word byte enable used for instruction fetches
package imem_dmem_arbiter_pkg;

    // Width of the registered request fields; the arbiter's XLEN must match.
    localparam int unsigned ArbXlen = 32;

    // Starvation counter width; holds STARVE_MAX values up to 15.
    localparam int unsigned StarveW = 4;

    localparam logic [3:0] BE_WORD = 4'hF;

    typedef enum logic [1:0] {
        ArbIdle,
        ArbReq,
        ArbResp
    } arb_state_e;

    typedef enum logic [1:0] {
        OwnNone,
        OwnIf,
        OwnLsu
    } arb_owner_e;

    typedef struct packed {
        logic               we;
        logic [3:0]         be;
        logic [ArbXlen-1:0] addr;
        logic [ArbXlen-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/imem_dmem_arbiter_pick.sv
// Combinational winner selection for the memory arbiter.
//   if_req_i     : fetch port is requesting
//   lsu_req_i    : load/store port is requesting
//   starve_cnt_i : consecutive LSU wins while fetch was waiting
//   winner_o     : selected owner (OwnNone when nobody requests)
//   starve_cnt_o : counter value to store if this arbitration is taken
module arb_pick
    import imem_dmem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic               if_req_i,
    input  logic               lsu_req_i,
    input  logic [StarveW-1:0] starve_cnt_i,
    output arb_owner_e         winner_o,
    output logic [StarveW-1:0] starve_cnt_o
);

    localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_MAX);

    logic force_if;

    assign force_if = if_req_i && (starve_cnt_i == StarveMax);

    always_comb begin
        winner_o     = OwnNone;
        starve_cnt_o = '0;
        if (lsu_req_i && !force_if) begin
            winner_o = OwnLsu;
            // LSU can only win over a waiting fetch below StarveMax, so the
            // increment never passes the saturation point.
            if (if_req_i) begin
                starve_cnt_o = starve_cnt_i + 1'b1;
            end
        end else if (if_req_i) begin
            winner_o = OwnIf;
        end
    end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port memory between instruction fetch (IF) and the
// load/store unit (LSU). LSU has priority; a starvation counter forces an IF
// win after STARVE_MAX consecutive LSU wins while IF waits. One outstanding
// transaction at a time.
//   clk_i, rstn_i          : clock, asynchronous active-low reset
//   if_*                   : fetch request (req/addr) and response (gnt/rvalid/rdata)
//   lsu_*                  : load/store request (req/we/be/addr/wdata) and response
//   mem_req_o..mem_wdata_o : registered request towards the memory
//   mem_gnt_i, mem_rvalid_i, mem_rdata_i : memory handshake and read data
module imem_dmem_arbiter
    import imem_dmem_arbiter_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic            clk_i,
    input  logic            rstn_i,

    input  logic            if_req_i,
    input  logic [XLEN-1:0] if_addr_i,
    output logic            if_gnt_o,
    output logic            if_rvalid_o,
    output logic [XLEN-1:0] if_rdata_o,

    input  logic            lsu_req_i,
    input  logic            lsu_we_i,
    input  logic [3:0]      lsu_be_i,
    input  logic [XLEN-1:0] lsu_addr_i,
    input  logic [XLEN-1:0] lsu_wdata_i,
    output logic            lsu_gnt_o,
    output logic            lsu_rvalid_o,
    output logic [XLEN-1:0] lsu_rdata_o,

    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [3:0]      mem_be_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i
);

    arb_state_e         state_q, state_d;
    arb_owner_e         owner_q, owner_d;
    logic [StarveW-1:0] starve_q, starve_d;
    mem_req_t           req_q, req_d;
    logic [XLEN-1:0]    if_rdata_q, lsu_rdata_q;

    logic               gnt_fire;
    logic               zero_lat;
    logic               resp_fire;
    logic               arb_en;
    logic               pick_if_req;
    logic               pick_lsu_req;
    arb_owner_e         pick_owner;
    logic [StarveW-1:0] pick_starve;

    assign gnt_fire  = (state_q == ArbReq) && mem_gnt_i;
    assign zero_lat  = gnt_fire && mem_rvalid_i;
    assign resp_fire = ((state_q == ArbResp) && mem_rvalid_i) || zero_lat;
    assign arb_en    = (state_q == ArbIdle) || resp_fire;

    // On a zero-latency completion the owner's req is still the one being
    // granted this cycle, so it must not be counted as a fresh request.
    assign pick_if_req  = if_req_i && !(zero_lat && (owner_q == OwnIf));
    assign pick_lsu_req = lsu_req_i && !(zero_lat && (owner_q == OwnLsu));

    arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb_pick (
        .if_req_i     (pick_if_req),
        .lsu_req_i    (pick_lsu_req),
        .starve_cnt_i (starve_q),
        .winner_o     (pick_owner),
        .starve_cnt_o (pick_starve)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        starve_d = starve_q;
        req_d    = req_q;

        if (gnt_fire) begin
            state_d = ArbResp;
        end

        if (arb_en) begin
            starve_d = pick_starve;
            owner_d  = pick_owner;
            unique case (pick_owner)
                OwnLsu: begin
                    state_d = ArbReq;
                    req_d   = '{we: lsu_we_i, be: lsu_be_i, addr: lsu_addr_i,
                                wdata: lsu_wdata_i};
                end
                OwnIf: begin
                    state_d = ArbReq;
                    req_d   = '{we: 1'b0, be: BE_WORD, addr: if_addr_i, wdata: '0};
                end
                default: begin
                    state_d = ArbIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ArbIdle;
            owner_q     <= OwnNone;
            starve_q    <= '0;
            req_q       <= '0;
            if_rdata_q  <= '0;
            lsu_rdata_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
            req_q    <= req_d;
            if (if_rvalid_o) begin
                if_rdata_q <= mem_rdata_i;
            end
            if (lsu_rvalid_o) begin
                lsu_rdata_q <= mem_rdata_i;
            end
        end
    end

    assign if_gnt_o     = gnt_fire && (owner_q == OwnIf);
    assign lsu_gnt_o    = gnt_fire && (owner_q == OwnLsu);
    assign if_rvalid_o  = resp_fire && (owner_q == OwnIf);
    assign lsu_rvalid_o = resp_fire && (owner_q == OwnLsu);

    // Read data passes straight through on the response cycle, then holds.
    assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : if_rdata_q;
    assign lsu_rdata_o = lsu_rvalid_o ? mem_rdata_i : lsu_rdata_q;

    assign mem_req_o   = (state_q == ArbReq);
    assign mem_we_o    = req_q.we;
    assign mem_be_o    = req_q.be;
    assign mem_addr_o  = req_q.addr;
    assign mem_wdata_o = req_q.wdata;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
module tb_imem_dmem_arbiter;

    logic        clk;
    logic        rstn;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        lsu_req;
    logic        lsu_we;
    logic [3:0]  lsu_be;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_gnt;
    logic        lsu_rvalid;
    logic [31:0] lsu_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    imem_dmem_arbiter #(
        .XLEN       (32),
        .STARVE_MAX (4)
    ) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .if_req_i     (if_req),
        .if_addr_i    (if_addr),
        .if_gnt_o     (if_gnt),
        .if_rvalid_o  (if_rvalid),
        .if_rdata_o   (if_rdata),
        .lsu_req_i    (lsu_req),
        .lsu_we_i     (lsu_we),
        .lsu_be_i     (lsu_be),
        .lsu_addr_i   (lsu_addr),
        .lsu_wdata_i  (lsu_wdata),
        .lsu_gnt_o    (lsu_gnt),
        .lsu_rvalid_o (lsu_rvalid),
        .lsu_rdata_o  (lsu_rdata),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_be_o     (mem_be),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_gnt_i    (mem_gnt),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #1;
        checks++;
        if ({mem_req, if_gnt, lsu_gnt, if_rvalid, lsu_rvalid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {mem_req, if_gnt, lsu_gnt, if_rvalid, lsu_rvalid});
        end
        checks++;
        if ({mem_we, mem_be, mem_addr, mem_wdata, if_rdata, lsu_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_data: got be=%h addr=%h wdata=%h ifr=%h lsur=%h expected 0",
                     mem_be, mem_addr, mem_wdata, if_rdata, lsu_rdata);
        end
        step();
        step();
        rstn = 1'b1;
        step();
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got mem_req=%b expected 0", mem_req);
        end
    endtask

    task automatic test_if_alone();
        if_req  = 1'b1;
        if_addr = 32'h100;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL if_cycle0_req: got %b expected 0", mem_req);
        end
        step();
        mem_gnt = 1'b1;
        #1;
        checks++;
        if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b0, 4'hF, 32'h100, 32'h0}) begin
            errors++;
            $display("FAIL if_mem_fields: got req=%b we=%b be=%h addr=%h wdata=%h expected 1 0 f 100 0",
                     mem_req, mem_we, mem_be, mem_addr, mem_wdata);
        end
        checks++;
        if ({if_gnt, lsu_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL if_gnt: got if=%b lsu=%b expected 1 0", if_gnt, lsu_gnt);
        end
        if_req = 1'b0;
        step();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h00500093;
        #1;
        checks++;
        if ({mem_req, if_gnt, if_rvalid, lsu_rvalid, if_rdata} !== {4'b0010, 32'h00500093}) begin
            errors++;
            $display("FAIL if_rvalid: got req=%b gnt=%b rv=%b lrv=%b rdata=%h expected 0 0 1 0 00500093",
                     mem_req, if_gnt, if_rvalid, lsu_rvalid, if_rdata);
        end
        step();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'hFFFF_FFFF;
        #1;
        checks++;
        if ({mem_req, if_rvalid, if_rdata} !== {2'b00, 32'h00500093}) begin
            errors++;
            $display("FAIL if_hold: got req=%b rv=%b rdata=%h expected 0 0 00500093",
                     mem_req, if_rvalid, if_rdata);
        end
    endtask

    task automatic test_mid_reset();
        if_req  = 1'b1;
        if_addr = 32'h104;
        step();
        mem_gnt = 1'b1;
        if_req  = 1'b0;
        step();
        // Now waiting for the response; abort it.
        mem_gnt    = 1'b0;
        rstn       = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        #1;
        checks++;
        if ({mem_req, if_rvalid, lsu_rvalid, if_gnt, lsu_gnt} !== 5'b0) begin
            errors++;
            $display("FAIL midrst_ctrl: got %b expected 00000",
                     {mem_req, if_rvalid, lsu_rvalid, if_gnt, lsu_gnt});
        end
        checks++;
        if ({mem_addr, if_rdata} !== 64'h0) begin
            errors++;
            $display("FAIL midrst_data: got addr=%h ifr=%h expected 0 0", mem_addr, if_rdata);
        end
        step();
        rstn       = 1'b1;
        mem_rvalid = 1'b0;
        step();
        mem_rvalid = 1'b1;
        #1;
        checks++;
        if ({if_rvalid, lsu_rvalid, mem_req, if_rdata, lsu_rdata} !== 67'h0) begin
            errors++;
            $display("FAIL midrst_late_rvalid: got rv=%b lrv=%b req=%b ifr=%h lsur=%h expected 0",
                     if_rvalid, lsu_rvalid, mem_req, if_rdata, lsu_rdata);
        end
        step();
        mem_rvalid = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL midrst_idle: got mem_req=%b expected 0", mem_req);
        end
    endtask

    task automatic test_simultaneous();
        if_req    = 1'b1;
        if_addr   = 32'h200;
        lsu_req   = 1'b1;
        lsu_we    = 1'b1;
        lsu_be    = 4'h3;
        lsu_addr  = 32'h40;
        lsu_wdata = 32'hDEADBEEF;
        step();
        mem_gnt = 1'b1;
        #1;
        checks++;
        if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'h3, 32'h40, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL sim_lsu_fields: got req=%b we=%b be=%h addr=%h wdata=%h expected 1 1 3 40 deadbeef",
                     mem_req, mem_we, mem_be, mem_addr, mem_wdata);
        end
        checks++;
        if ({if_gnt, lsu_gnt} !== 2'b01) begin
            errors++;
            $display("FAIL sim_lsu_gnt: got if=%b lsu=%b expected 0 1", if_gnt, lsu_gnt);
        end
        lsu_req = 1'b0;
        step();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0;
        #1;
        checks++;
        if ({lsu_rvalid, if_rvalid} !== 2'b10) begin
            errors++;
            $display("FAIL sim_lsu_rvalid: got lsu=%b if=%b expected 1 0", lsu_rvalid, if_rvalid);
        end
        step();
        mem_rvalid = 1'b0;
        mem_gnt    = 1'b1;
        #1;
        checks++;
        if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata, if_gnt, lsu_gnt}
            !== {1'b1, 1'b0, 4'hF, 32'h200, 32'h0, 2'b10}) begin
            errors++;
            $display("FAIL sim_if_second: got req=%b we=%b be=%h addr=%h wdata=%h gnt=%b%b expected 1 0 f 200 0 10",
                     mem_req, mem_we, mem_be, mem_addr, mem_wdata, if_gnt, lsu_gnt);
        end
        if_req = 1'b0;
        step();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hA5A5_0001;
        #1;
        checks++;
        if ({if_rvalid, lsu_rvalid, if_rdata} !== {2'b10, 32'hA5A5_0001}) begin
            errors++;
            $display("FAIL sim_if_rvalid: got rv=%b lrv=%b rdata=%h expected 1 0 a5a50001",
                     if_rvalid, lsu_rvalid, if_rdata);
        end
        step();
        mem_rvalid = 1'b0;
    endtask

    task automatic test_starvation();
        // Bit i set: transaction i must go to IF (4 LSU wins, then IF).
        logic [9:0] exp_if = 10'b10_0001_0000;
        if_req   = 1'b1;
        if_addr  = 32'h400;
        lsu_req  = 1'b1;
        lsu_we   = 1'b0;
        lsu_be   = 4'hF;
        lsu_addr = 32'h500;
        step();
        for (int i = 0; i < 10; i++) begin
            mem_gnt = 1'b1;
            #1;
            checks++;
            if ({mem_req, if_gnt, lsu_gnt} !== {1'b1, exp_if[i], !exp_if[i]}) begin
                errors++;
                $display("FAIL starve_gnt[%0d]: got req=%b if=%b lsu=%b expected 1 %b %b",
                         i, mem_req, if_gnt, lsu_gnt, exp_if[i], !exp_if[i]);
            end
            step();
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b1;
            if (i == 9) begin
                if_req  = 1'b0;
                lsu_req = 1'b0;
            end
            step();
            mem_rvalid = 1'b0;
        end
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL starve_idle: got mem_req=%b expected 0", mem_req);
        end
    endtask

    task automatic test_stall();
        lsu_req   = 1'b1;
        lsu_we    = 1'b0;
        lsu_be    = 4'hF;
        lsu_addr  = 32'h80;
        lsu_wdata = 32'h1234_5678;
        step();
        lsu_addr  = 32'hBAD0_0000;
        lsu_wdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            mem_rvalid = (i == 1);
            #1;
            checks++;
            if ({mem_req, mem_addr, mem_wdata, if_gnt, lsu_gnt, lsu_rvalid}
                !== {1'b1, 32'h80, 32'h1234_5678, 3'b000}) begin
                errors++;
                $display("FAIL stall[%0d]: got req=%b addr=%h wdata=%h gnt=%b%b lrv=%b expected 1 80 12345678 00 0",
                         i, mem_req, mem_addr, mem_wdata, if_gnt, lsu_gnt, lsu_rvalid);
            end
            step();
        end
        mem_rvalid = 1'b0;
        mem_gnt    = 1'b1;
        #1;
        checks++;
        if ({lsu_gnt, if_gnt, mem_addr} !== {2'b10, 32'h80}) begin
            errors++;
            $display("FAIL stall_gnt: got lsu=%b if=%b addr=%h expected 1 0 80", lsu_gnt, if_gnt, mem_addr);
        end
        lsu_req = 1'b0;
        step();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFEF00D;
        #1;
        checks++;
        if ({lsu_rvalid, lsu_rdata} !== {1'b1, 32'hCAFEF00D}) begin
            errors++;
            $display("FAIL stall_rdata: got rv=%b rdata=%h expected 1 cafef00d", lsu_rvalid, lsu_rdata);
        end
        step();
        mem_rvalid = 1'b0;
    endtask

    task automatic test_zero_latency();
        // A grant in IDLE must be ignored.
        mem_gnt = 1'b1;
        #1;
        checks++;
        if ({if_gnt, lsu_gnt, mem_req} !== 3'b000) begin
            errors++;
            $display("FAIL zl_idle_gnt: got %b expected 000", {if_gnt, lsu_gnt, mem_req});
        end
        mem_gnt  = 1'b0;
        if_req   = 1'b1;
        if_addr  = 32'h300;
        lsu_req  = 1'b1;
        lsu_we   = 1'b0;
        lsu_addr = 32'h44;
        step();
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_2222;
        #1;
        checks++;
        if ({lsu_gnt, lsu_rvalid, lsu_rdata, if_gnt, if_rvalid} !== {2'b11, 32'h1111_2222, 2'b00}) begin
            errors++;
            $display("FAIL zl_lsu: got gnt=%b rv=%b rdata=%h ifgnt=%b ifrv=%b expected 1 1 11112222 0 0",
                     lsu_gnt, lsu_rvalid, lsu_rdata, if_gnt, if_rvalid);
        end
        lsu_req = 1'b0;
        step();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_addr, mem_be, if_gnt, lsu_rvalid} !== {1'b1, 32'h300, 4'hF, 2'b00}) begin
            errors++;
            $display("FAIL zl_next_req: got req=%b addr=%h be=%h ifgnt=%b lrv=%b expected 1 300 f 0 0",
                     mem_req, mem_addr, mem_be, if_gnt, lsu_rvalid);
        end
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0BAD_C0DE;
        #1;
        checks++;
        if ({if_gnt, if_rvalid, if_rdata, lsu_rvalid} !== {2'b11, 32'h0BAD_C0DE, 1'b0}) begin
            errors++;
            $display("FAIL zl_if: got gnt=%b rv=%b rdata=%h lrv=%b expected 1 1 0badc0de 0",
                     if_gnt, if_rvalid, if_rdata, lsu_rvalid);
        end
        if_req = 1'b0;
        step();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        #1;
        checks++;
        if ({mem_req, if_rvalid, lsu_rvalid} !== 3'b000) begin
            errors++;
            $display("FAIL zl_idle: got %b expected 000", {mem_req, if_rvalid, lsu_rvalid});
        end
    endtask

    initial begin
        rstn       = 1'b0;
        if_req     = 1'b0;
        if_addr    = '0;
        lsu_req    = 1'b0;
        lsu_we     = 1'b0;
        lsu_be     = '0;
        lsu_addr   = '0;
        lsu_wdata  = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        test_reset();
        test_if_alone();
        test_mid_reset();
        test_simultaneous();
        test_starvation();
        test_stall();
        test_zero_latency();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: got no completion expected finish before 100000");
        $fatal(1);
    end

endmodule
